// File: rtl/prog_instmem_if.sv
// ---------------------------------------------------------------------------
// prog_instmem_if
//   Bus bundle between a core/loader (master) and the loadable instruction
//   memory prog_instmem (slave).
//
//   Load channel  : ld_valid, ld_ready, ld_data, ld_last
//   Control       : reload, run, prog_len
//   Fetch channel : pc, fetch_en, inst, inst_valid
//   Optional      : par_err (only when INSTMEM_PARITY_EN is defined)
//
//   Load handshake (valid/ready): a word transfers on a rising clk edge where
//   ld_valid && ld_ready are both high. The master holds ld_data/ld_last
//   stable while ld_valid is high and ld_ready is low. The master may raise
//   ld_valid at any time. ld_ready does not depend on ld_valid.
//
//   Parameters: IW instruction width, AW address width.
// ---------------------------------------------------------------------------
interface prog_instmem_if #(
  parameter int IW = 9,
  parameter int AW = 8
);
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          reload;
  logic [AW-1:0] pc;
  logic          fetch_en;
  logic [IW-1:0] inst;
  logic          inst_valid;
  logic          run;
  logic [AW:0]   prog_len;
`ifdef INSTMEM_PARITY_EN
  logic          par_err;
`endif

`ifdef INSTMEM_PARITY_EN
  modport master (
    output ld_valid, ld_data, ld_last, reload, pc, fetch_en,
    input  ld_ready, inst, inst_valid, run, prog_len, par_err
  );
  modport slave (
    input  ld_valid, ld_data, ld_last, reload, pc, fetch_en,
    output ld_ready, inst, inst_valid, run, prog_len, par_err
  );
`else
  modport master (
    output ld_valid, ld_data, ld_last, reload, pc, fetch_en,
    input  ld_ready, inst, inst_valid, run, prog_len
  );
  modport slave (
    input  ld_valid, ld_data, ld_last, reload, pc, fetch_en,
    output ld_ready, inst, inst_valid, run, prog_len
  );
`endif

endinterface

// File: rtl/prog_instmem.sv
// ---------------------------------------------------------------------------
// prog_instmem
//   Loadable instruction memory. After reset it sits in LOAD and accepts
//   program words on the load channel, writing them from address 0 upward.
//   The word flagged ld_last, or the word landing in the last location, ends
//   loading and moves to RUN. In RUN it serves registered fetches with one
//   cycle of latency. Addresses at or beyond prog_len read as NOP. A reload
//   pulse in RUN returns to LOAD with an empty program.
//
//   Optional feature macro: INSTMEM_PARITY_EN
//     Stores an even-parity bit with every word. A fetch whose stored word
//     fails the parity check raises bus.par_err with inst_valid.
//
//   Parameters:
//     IW    instruction width
//     AW    pc / address width
//     DEPTH number of words (2 <= DEPTH <= 2**AW)
//     NOP   value returned for unloaded / out-of-range addresses
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     bus          prog_instmem_if.slave (load, fetch, status)
//     dbg_state_o  current FSM state (0 = LOAD, 1 = RUN)
// ---------------------------------------------------------------------------
module prog_instmem #(
  parameter int          IW    = 9,
  parameter int          AW    = 8,
  parameter int          DEPTH = 256,
  parameter logic [IW-1:0] NOP = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_instmem_if.slave  bus,
  output logic           dbg_state_o
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTMEM_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q;
  logic [IDXW-1:0] wptr_q;
  logic [AW:0]     prog_len_q;
  logic [IW-1:0]   inst_q;
  logic            inst_valid_q;
`ifdef INSTMEM_PARITY_EN
  logic            par_err_q;
`endif

  // Storage is deliberately not reset: prog_len_q gates every read, so stale
  // contents are never visible after reset or reload.
  logic [MW-1:0] mem_q [DEPTH];

  logic          ld_fire;
  logic          ld_done;
  logic          rd_hit;
  logic [MW-1:0] rd_word;
  logic [MW-1:0] wr_word;
  logic          rd_par_bad;

  assign ld_fire = bus.ld_valid && (state_q == LOAD);
  // The final location ends loading even without ld_last, so prog_len_q
  // can never exceed DEPTH.
  assign ld_done = ld_fire && (bus.ld_last || (wptr_q == IDXW'(DEPTH - 1)));

  // prog_len_q <= DEPTH, so a hit also guarantees pc < DEPTH and the
  // truncated index below never aliases.
  assign rd_hit  = ({1'b0, bus.pc} < prog_len_q);
  assign rd_word = mem_q[bus.pc[IDXW-1:0]];

`ifdef INSTMEM_PARITY_EN
  // Even parity over the whole stored word: XOR of all MW bits is zero.
  assign wr_word    = {^bus.ld_data, bus.ld_data};
  assign rd_par_bad = ^rd_word;
`else
  assign wr_word    = bus.ld_data;
  assign rd_par_bad = 1'b0;
`endif

  // Memory write port; active only in LOAD, so never concurrent with a read.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem_q[wptr_q] <= wr_word;
    end
  end

  // Control FSM with registered fetch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      wptr_q       <= '0;
      prog_len_q   <= '0;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
`ifdef INSTMEM_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          // Fetches are ignored while loading.
          inst_q       <= NOP;
          inst_valid_q <= 1'b0;
          if (ld_fire) begin
            wptr_q     <= wptr_q + 1'b1;
            prog_len_q <= prog_len_q + 1'b1;
            if (ld_done) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.reload) begin
            // Reload takes priority over a fetch in the same cycle.
            state_q      <= LOAD;
            wptr_q       <= '0;
            prog_len_q   <= '0;
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
`ifdef INSTMEM_PARITY_EN
            par_err_q    <= 1'b0;
`endif
          end else if (bus.fetch_en) begin
            inst_q       <= rd_hit ? rd_word[IW-1:0] : NOP;
            inst_valid_q <= 1'b1;
`ifdef INSTMEM_PARITY_EN
            par_err_q    <= rd_hit && rd_par_bad;
`endif
          end else begin
            inst_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign bus.ld_ready   = (state_q == LOAD);
  assign bus.run        = (state_q == RUN);
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.prog_len   = prog_len_q;
`ifdef INSTMEM_PARITY_EN
  assign bus.par_err    = par_err_q;
`endif
  assign dbg_state_o    = state_q;

  // Parity is only consumed when the feature is built in.
  logic unused_par;
  assign unused_par = rd_par_bad;

endmodule
